// File: rtl/uart_tx_fifo.sv
// Transmit FIFO in front of UartTx: queues producer bytes and launches one
// UART frame at a time, holding tx_data until the transmitter reports tx_done.
module uart_tx_fifo #(
  parameter  int DATA_BITS = 8,
  parameter  int DEPTH     = 16,
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 wr_ready,
  output logic                 tx_start,
  output logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_done,
  output logic                 tx_busy,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  input  logic                 ovf_clr
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT
  } state_e;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 ovf_q, ovf_d;
  logic                 push;
  logic                 pop;

  // No write bypass: a full FIFO refuses writes even while it is popping.
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign wr_ready = !full;
  assign push     = wr_valid && wr_ready;

  assign count    = count_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign tx_busy  = tx_busy_q;
  assign overflow = ovf_q;

  always_comb begin
    state_d    = state_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    tx_busy_d  = tx_busy_q;
    pop        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          tx_data_d = mem_q[rptr_q];
          rptr_d    = rptr_q + 1'b1;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        tx_start_d = 1'b1;
        tx_busy_d  = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done) begin
          tx_busy_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // A new overflow takes priority over a clear in the same cycle.
    ovf_d = ovf_q;
    if (wr_valid && !wr_ready) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      tx_busy_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      tx_busy_q  <= tx_busy_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage is data-only; occupancy and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= wr_data;
    end
  end

endmodule
